// File: rtl/axi_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions for the initiator and the bus-side blocks.
//   state_t    : control states of the single-outstanding initiator
//   RESP_OKAY  : 1-bit response code for a successful access
//   RESP_ERR   : 1-bit response code for a failed access
// ----------------------------------------------------------------------------
package axi_lite_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/axi_lite_master.sv
// ----------------------------------------------------------------------------
// axi_lite_master
// Single-outstanding AXI4-Lite initiator. A command accepted on the cmd_*
// interface becomes one AXI-Lite write (AW + W, then B) or read (AR, then R).
// The captured result is presented on rsp_* until consumed. Every output is
// driven straight from a flop.
//
// Ports
//   m1_axi_aclk, m1_axi_aresetn : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_write, cmd_addr         : access type and byte address
//   cmd_wdata, cmd_wstrb        : write data and byte enables (writes only)
//   rsp_valid/rsp_ready         : response handshake
//   rsp_write, rsp_rdata        : echoed access type, read data (0 on writes)
//   rsp_err                     : captured bresp/rresp
//   m1_axi_aw*, m1_axi_w*       : write address / write data channels
//   m1_axi_b*                   : write response channel
//   m1_axi_ar*, m1_axi_r*       : read address / read data channels
// ----------------------------------------------------------------------------
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    m1_axi_aclk,
   input  logic                    m1_axi_aresetn,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,

   output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
   output logic                    m1_axi_awvalid,
   input  logic                    m1_axi_awready,
   output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
   output logic [DATA_WIDTH/8:0]   m1_axi_wstrb,
   output logic                    m1_axi_wvalid,
   input  logic                    m1_axi_wready,
   input  logic                    m1_axi_bresp,
   input  logic                    m1_axi_bvalid,
   output logic                    m1_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
   output logic                    m1_axi_arvalid,
   input  logic                    m1_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
   input  logic                    m1_axi_rresp,
   input  logic                    m1_axi_rvalid,
   output logic                    m1_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;

   state_t                  state, state_nxt;
   logic                    aw_done, aw_done_nxt;
   logic                    w_done, w_done_nxt;

   logic                    cmd_ready_nxt;
   logic                    rsp_valid_nxt;
   logic                    rsp_write_nxt;
   logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
   logic                    rsp_err_nxt;
   logic [ADDR_WIDTH-1:0]   awaddr_nxt;
   logic                    awvalid_nxt;
   logic [DATA_WIDTH-1:0]   wdata_nxt;
   logic [STRB_W:0]         wstrb_nxt;
   logic                    wvalid_nxt;
   logic                    bready_nxt;
   logic [ADDR_WIDTH-1:0]   araddr_nxt;
   logic                    arvalid_nxt;
   logic                    rready_nxt;

   logic                    aw_fire, w_fire;
   logic                    aw_complete, w_complete;

   assign aw_fire     = m1_axi_awvalid && m1_axi_awready;
   assign w_fire      = m1_axi_wvalid  && m1_axi_wready;
   // A channel counts as finished if it completed earlier or completes now.
   assign aw_complete = aw_done || aw_fire;
   assign w_complete  = w_done  || w_fire;

   // Next-state and next-output logic. Every output is a flop; this block
   // computes what each flop loads, holding its value by default.
   always_comb begin
      state_nxt     = state;
      aw_done_nxt   = aw_done;
      w_done_nxt    = w_done;
      cmd_ready_nxt = cmd_ready;
      rsp_valid_nxt = rsp_valid;
      rsp_write_nxt = rsp_write;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      awaddr_nxt    = m1_axi_awaddr;
      awvalid_nxt   = m1_axi_awvalid;
      wdata_nxt     = m1_axi_wdata;
      wstrb_nxt     = m1_axi_wstrb;
      wvalid_nxt    = m1_axi_wvalid;
      bready_nxt    = m1_axi_bready;
      araddr_nxt    = m1_axi_araddr;
      arvalid_nxt   = m1_axi_arvalid;
      rready_nxt    = m1_axi_rready;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cmd_ready_nxt = 1'b0;
               if (cmd_write) begin
                  awaddr_nxt  = cmd_addr;
                  wdata_nxt   = cmd_wdata;
                  // Strobe port is one bit wider than the byte count; the
                  // extra MSB is never used and stays low.
                  wstrb_nxt   = {1'b0, cmd_wstrb};
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
                  aw_done_nxt = 1'b0;
                  w_done_nxt  = 1'b0;
                  state_nxt   = WR;
               end else begin
                  araddr_nxt  = cmd_addr;
                  arvalid_nxt = 1'b1;
                  state_nxt   = RD_ADDR;
               end
            end
         end

         WR: begin
            // AW and W complete independently; each valid falls only after
            // its own handshake.
            if (aw_fire) begin
               awvalid_nxt = 1'b0;
               aw_done_nxt = 1'b1;
            end
            if (w_fire) begin
               wvalid_nxt = 1'b0;
               w_done_nxt = 1'b1;
            end
            if (aw_complete && w_complete) begin
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               bready_nxt  = 1'b1;
               state_nxt   = WR_RESP;
            end
         end

         WR_RESP: begin
            if (m1_axi_bvalid && m1_axi_bready) begin
               bready_nxt    = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_write_nxt = 1'b1;
               rsp_rdata_nxt = '0;
               rsp_err_nxt   = (m1_axi_bresp == RESP_ERR);
               state_nxt     = RSP;
            end
         end

         RD_ADDR: begin
            if (m1_axi_arvalid && m1_axi_arready) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = RD_DATA;
            end
         end

         RD_DATA: begin
            if (m1_axi_rvalid && m1_axi_rready) begin
               rready_nxt    = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_write_nxt = 1'b0;
               rsp_rdata_nxt = m1_axi_rdata;
               rsp_err_nxt   = (m1_axi_rresp == RESP_ERR);
               state_nxt     = RSP;
            end
         end

         RSP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end

         default: begin
            // Unreachable encodings recover to an idle, quiet bus.
            awvalid_nxt   = 1'b0;
            wvalid_nxt    = 1'b0;
            bready_nxt    = 1'b0;
            arvalid_nxt   = 1'b0;
            rready_nxt    = 1'b0;
            rsp_valid_nxt = 1'b0;
            cmd_ready_nxt = 1'b1;
            state_nxt     = IDLE;
         end
      endcase
   end

   // State and output registers. Reset clears everything (including data)
   // so a transaction in flight is dropped without producing a response.
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn) begin
         state          <= IDLE;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         cmd_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_write      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_err        <= RESP_OKAY;
         m1_axi_awaddr  <= '0;
         m1_axi_awvalid <= 1'b0;
         m1_axi_wdata   <= '0;
         m1_axi_wstrb   <= '0;
         m1_axi_wvalid  <= 1'b0;
         m1_axi_bready  <= 1'b0;
         m1_axi_araddr  <= '0;
         m1_axi_arvalid <= 1'b0;
         m1_axi_rready  <= 1'b0;
      end else begin
         state          <= state_nxt;
         aw_done        <= aw_done_nxt;
         w_done         <= w_done_nxt;
         cmd_ready      <= cmd_ready_nxt;
         rsp_valid      <= rsp_valid_nxt;
         rsp_write      <= rsp_write_nxt;
         rsp_rdata      <= rsp_rdata_nxt;
         rsp_err        <= rsp_err_nxt;
         m1_axi_awaddr  <= awaddr_nxt;
         m1_axi_awvalid <= awvalid_nxt;
         m1_axi_wdata   <= wdata_nxt;
         m1_axi_wstrb   <= wstrb_nxt;
         m1_axi_wvalid  <= wvalid_nxt;
         m1_axi_bready  <= bready_nxt;
         m1_axi_araddr  <= araddr_nxt;
         m1_axi_arvalid <= arvalid_nxt;
         m1_axi_rready  <= rready_nxt;
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_master
// Self-checking bench for axi_lite_master: a directed vector table, hand-made
// sequences for reset and stray responses, and randomized transactions, all
// against an in-bench slave with per-channel wait counts and a latency model.
// ----------------------------------------------------------------------------
module tb_axi_lite_master;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = DW / 8;
   localparam int BUDGET = 200;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready;
   logic [DW-1:0] wdata, rdata;
   logic [SW:0]   wstrb;
   logic          bresp, bvalid, bready;
   logic          arvalid, arready;
   logic          rresp, rvalid, rready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .m1_axi_aclk    (clk),
      .m1_axi_aresetn (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_write      (cmd_write),
      .cmd_addr       (cmd_addr),
      .cmd_wdata      (cmd_wdata),
      .cmd_wstrb      (cmd_wstrb),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_write      (rsp_write),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .m1_axi_awaddr  (awaddr),
      .m1_axi_awvalid (awvalid),
      .m1_axi_awready (awready),
      .m1_axi_wdata   (wdata),
      .m1_axi_wstrb   (wstrb),
      .m1_axi_wvalid  (wvalid),
      .m1_axi_wready  (wready),
      .m1_axi_bresp   (bresp),
      .m1_axi_bvalid  (bvalid),
      .m1_axi_bready  (bready),
      .m1_axi_araddr  (araddr),
      .m1_axi_arvalid (arvalid),
      .m1_axi_arready (arready),
      .m1_axi_rdata   (rdata),
      .m1_axi_rresp   (rresp),
      .m1_axi_rvalid  (rvalid),
      .m1_axi_rready  (rready)
   );

   // One transaction: command fields, slave behaviour, expected response.
   // Delays are the number of cycles the slave lets a valid wait before
   // answering; exp_lat counts clock edges from the command-accept edge to
   // the edge after which rsp_valid is first high.
   typedef struct {
      bit        wr;
      bit [7:0]  addr;
      bit [31:0] wdata;
      bit [3:0]  wstrb;
      bit [31:0] sdata;
      bit        sresp;
      int        aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
      int        exp_lat;
      bit [31:0] exp_rdata;
      bit        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit wr, bit [7:0] addr, bit [31:0] wd, bit [3:0] ws,
                               bit [31:0] sd, bit sr, int awd, int wd_d, int bd,
                               int ard, int rd, int rspd, int lat, bit [31:0] erd, bit ee);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wd; v.wstrb = ws;
      v.sdata = sd; v.sresp = sr;
      v.aw_dly = awd; v.w_dly = wd_d; v.b_dly = bd;
      v.ar_dly = ard; v.r_dly = rd; v.rsp_dly = rspd;
      v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = ee;
      return v;
   endfunction

   // Reference model: valids rise one edge after accept; a channel with wait
   // d completes d edges later; the response phase needs one edge for its
   // ready to rise plus its own wait, and rsp_valid follows that handshake.
   function automatic vec_t model(vec_t v);
      vec_t r = v;
      int aw_e = 1 + v.aw_dly;
      int w_e  = 1 + v.w_dly;
      int both = (aw_e > w_e) ? aw_e : w_e;
      if (v.wr) begin
         r.exp_lat   = both + 1 + v.b_dly;
         r.exp_rdata = 32'h0;
      end else begin
         r.exp_lat   = (1 + v.ar_dly) + 1 + v.r_dly;
         r.exp_rdata = v.sdata;
      end
      r.exp_err = v.sresp;
      return r;
   endfunction

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 0; awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = '0;
   endtask

   // Drives one command and plays the slave cycle by cycle. Called at a
   // falling edge; samples DUT outputs at falling edges only.
   task automatic run_txn(input vec_t v, input string tag);
      bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
      bit rsp_seen = 0, fin = 0;
      int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, rsp_cnt = 0, e = 0;
      logic p_awv = 0, p_wv = 0, p_arv = 0, p_br = 0, p_rr = 0, p_rspv = 0;

      chk({tag, " cmd_ready before"}, cmd_ready, 1);
      cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      @(negedge clk);
      // Scramble command inputs so the DUT must rely on what it latched.
      cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
      cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

      while (!fin) begin
         if (p_awv && awready) aw_done = 1;
         if (p_wv  && wready)  w_done  = 1;
         if (p_arv && arready) ar_done = 1;
         if (p_br  && bvalid)  b_done  = 1;
         if (p_rr  && rvalid)  r_done  = 1;

         if (p_rspv && rsp_ready) begin
            chk({tag, " rsp_valid after consume"}, rsp_valid, 0);
            chk({tag, " cmd_ready after consume"}, cmd_ready, 1);
            fin = 1;
         end else begin
            chk({tag, " awvalid"}, awvalid, v.wr && !aw_done);
            chk({tag, " wvalid"},  wvalid,  v.wr && !w_done);
            chk({tag, " arvalid"}, arvalid, !v.wr && !ar_done);
            chk({tag, " bready"},  bready,  v.wr && aw_done && w_done && !b_done);
            chk({tag, " rready"},  rready,  !v.wr && ar_done && !r_done);
            chk({tag, " rsp_valid"}, rsp_valid, b_done || r_done);
            chk({tag, " cmd_ready busy"}, cmd_ready, 0);
            if (awvalid) chk({tag, " awaddr"}, awaddr, v.addr);
            if (wvalid) begin
               chk({tag, " wdata"}, wdata, v.wdata);
               chk({tag, " wstrb"}, wstrb, {1'b0, v.wstrb});
            end
            if (arvalid) chk({tag, " araddr"}, araddr, v.addr);
            if (rsp_valid) begin
               if (!rsp_seen) begin
                  rsp_seen = 1;
                  chk({tag, " latency"}, 64'(e), 64'(v.exp_lat));
               end
               chk({tag, " rsp_write"}, rsp_write, v.wr);
               chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
               chk({tag, " rsp_err"},   rsp_err,   v.exp_err);
            end
         end

         if (fin) begin
            idle_inputs();
         end else begin
            awready = awvalid && !aw_done && (aw_cnt >= v.aw_dly);
            if (awvalid && !aw_done) aw_cnt++;
            wready = wvalid && !w_done && (w_cnt >= v.w_dly);
            if (wvalid && !w_done) w_cnt++;
            arready = arvalid && !ar_done && (ar_cnt >= v.ar_dly);
            if (arvalid && !ar_done) ar_cnt++;
            bvalid = aw_done && w_done && !b_done && (b_cnt >= v.b_dly);
            bresp  = bvalid ? v.sresp : 1'b0;
            if (aw_done && w_done && !b_done) b_cnt++;
            rvalid = ar_done && !r_done && (r_cnt >= v.r_dly);
            rresp  = rvalid ? v.sresp : 1'b0;
            rdata  = rvalid ? v.sdata : 32'($urandom);
            if (ar_done && !r_done) r_cnt++;
            if (rsp_valid) begin
               if (rsp_cnt >= v.rsp_dly) begin
                  rsp_ready = 1; cmd_valid = 0;
               end else begin
                  // Competing command while the response is held back.
                  rsp_ready = 0; cmd_valid = 1; cmd_write = 0;
               end
               rsp_cnt++;
            end else begin
               rsp_ready = 0;
            end
            p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
            p_br = bready; p_rr = rready; p_rspv = rsp_valid;
            @(negedge clk);
            e++;
            if (e > BUDGET) begin
               checks++; errors++;
               $display("FAIL %s timeout actual=%0d cycles required<=%0d", tag, e, BUDGET);
               idle_inputs();
               fin = 1;
            end
         end
      end
   endtask

   vec_t dir[5];

   initial begin
      idle_inputs();

      // Directed vectors with hand-derived expectations.
      dir[0] = mk(1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h0, 0);
      dir[1] = mk(1, 8'h20, 32'hA5A50001, 4'h3, 32'h0, 0, 2, 0, 1, 0, 0, 0, 5, 32'h0, 0);
      dir[2] = mk(0, 8'h24, 32'h0, 4'h0, 32'h12345678, 1, 0, 0, 0, 0, 2, 0, 4, 32'h12345678, 1);
      dir[3] = mk(1, 8'h40, 32'h0000CAFE, 4'h5, 32'h0, 1, 0, 3, 0, 0, 0, 5, 5, 32'h0, 1);
      dir[4] = mk(0, 8'h7C, 32'h0, 4'h0, 32'h0BADF00D, 0, 0, 0, 0, 3, 0, 2, 5, 32'h0BADF00D, 0);

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst cmd_ready", cmd_ready, 1);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_write", rsp_write, 0);
      chk("rst rsp_rdata", rsp_rdata, 0);
      chk("rst rsp_err",   rsp_err,   0);
      chk("rst awaddr",  awaddr,  0);
      chk("rst awvalid", awvalid, 0);
      chk("rst wdata",   wdata,   0);
      chk("rst wstrb",   wstrb,   0);
      chk("rst wvalid",  wvalid,  0);
      chk("rst bready",  bready,  0);
      chk("rst araddr",  araddr,  0);
      chk("rst arvalid", arvalid, 0);
      chk("rst rready",  rready,  0);
      rst_n = 1;
      @(negedge clk);

      foreach (dir[i]) run_txn(dir[i], $sformatf("dir%0d", i));

      // Stray bvalid/rvalid while idle must be ignored.
      bvalid = 1; bresp = 1; rvalid = 1; rresp = 1; rdata = 32'hFFFF0000;
      repeat (3) begin
         @(negedge clk);
         chk("stray rsp_valid", rsp_valid, 0);
         chk("stray bready",    bready,    0);
         chk("stray rready",    rready,    0);
         chk("stray cmd_ready", cmd_ready, 1);
         chk("stray awvalid",   awvalid,   0);
         chk("stray arvalid",   arvalid,   0);
      end
      idle_inputs();
      run_txn(dir[0], "post-stray");

      // Reset in the middle of a read whose address is never accepted.
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h30;
      @(negedge clk);
      cmd_valid = 0;
      chk("midrst arvalid up", arvalid, 1);
      @(negedge clk);
      chk("midrst arvalid held", arvalid, 1);
      #2 rst_n = 0;
      #1;
      chk("midrst arvalid async", arvalid, 0);
      chk("midrst cmd_ready async", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1;
      repeat (4) begin
         @(negedge clk);
         chk("midrst rsp_valid", rsp_valid, 0);
         chk("midrst arvalid",   arvalid,   0);
         chk("midrst cmd_ready", cmd_ready, 1);
      end
      run_txn(dir[2], "post-reset");

      // Randomized traffic against the model.
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.wr      = 1'($urandom);
         v.addr    = 8'($urandom);
         v.wdata   = $urandom;
         v.wstrb   = 4'($urandom);
         v.sdata   = $urandom;
         v.sresp   = 1'($urandom);
         v.aw_dly  = $urandom_range(0, 3);
         v.w_dly   = $urandom_range(0, 3);
         v.b_dly   = $urandom_range(0, 3);
         v.ar_dly  = $urandom_range(0, 3);
         v.r_dly   = $urandom_range(0, 3);
         v.rsp_dly = $urandom_range(0, 3);
         v = model(v);
         run_txn(v, $sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
